// File: rtl/acc_stack_if.sv
// Bus bundle for the accumulator-with-shadow-stack block: control/data in,
// accumulator and stack status out.
interface acc_stack_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             notLoadA;
  logic [2:0]       op;
  logic [WIDTH-1:0] ALU_Result;
  logic             clrErr;
  logic [WIDTH-1:0] A_Result;
  logic             A_Zero;
  logic [CW-1:0]    stackCount;
  logic             stackFull;
  logic             stackEmpty;
  logic             stackErr;

  modport master (
    output notLoadA, op, ALU_Result, clrErr,
    input  A_Result, A_Zero, stackCount, stackFull, stackEmpty, stackErr
  );

  modport slave (
    input  notLoadA, op, ALU_Result, clrErr,
    output A_Result, A_Zero, stackCount, stackFull, stackEmpty, stackErr
  );
endinterface

// File: rtl/acc_stack.sv
// Accumulator register with shift/inc/dec/clear ops and a small LIFO shadow
// stack for saving/restoring it; sticky error flag on stack over/underflow.
module acc_stack #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  acc_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_INC  = 3'b011,
    OP_DEC  = 3'b100,
    OP_CLR  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_t;

  logic [WIDTH-1:0] a_reg, a_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             err_reg, err_next;
  logic             err_set;
  logic             push_en;
  logic             full, empty;
  logic [CW-1:0]    count_dec;
  logic [IW-1:0]    push_idx, pop_idx;

  // Entries are not reset; only those below count_reg are ever read back.
  logic [WIDTH-1:0] entry [0:(1<<IW)-1];

  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  assign count_dec = count_reg - CW'(1);
  assign push_idx  = count_reg[IW-1:0];
  assign pop_idx   = count_dec[IW-1:0];

  always_comb begin
    a_next     = a_reg;
    count_next = count_reg;
    err_set    = 1'b0;
    push_en    = 1'b0;
    if (!bus.notLoadA) begin
      case (op_t'(bus.op))
        OP_LOAD: a_next = bus.ALU_Result;
        OP_SHL:  a_next = {a_reg[WIDTH-2:0], 1'b0};
        OP_SHR:  a_next = {1'b0, a_reg[WIDTH-1:1]};
        OP_INC:  a_next = a_reg + WIDTH'(1);
        OP_DEC:  a_next = a_reg - WIDTH'(1);
        OP_CLR:  a_next = '0;
        OP_PUSH: begin
          if (full) begin
            err_set = 1'b1;
          end else begin
            push_en    = 1'b1;
            count_next = count_reg + CW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            err_set = 1'b1;
          end else begin
            a_next     = entry[pop_idx];
            count_next = count_dec;
          end
        end
        default: a_next = a_reg;
      endcase
    end
    // A new error wins over a simultaneous clear.
    if (err_set)
      err_next = 1'b1;
    else if (bus.clrErr)
      err_next = 1'b0;
    else
      err_next = err_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      a_reg     <= a_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en)
      entry[push_idx] <= a_reg;
  end

  assign bus.A_Result   = a_reg;
  assign bus.A_Zero     = (a_reg == '0);
  assign bus.stackCount = count_reg;
  assign bus.stackFull  = full;
  assign bus.stackEmpty = empty;
  assign bus.stackErr   = err_reg;
endmodule

// File: doc/acc_stack.md
ACC_STACK -- requirements
Module: acc_stack

Interface
REQ-001 Parameter WIDTH, default 5: accumulator width in bits, including carry bit (MSB); legal range ≥2.
REQ-002 Parameter DEPTH, default 4: number of shadow-stack entries; legal range ≥1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 notLoadA  input  1  active-low operation enable; high = hold all state.
REQ-006 op  input  3  operation select, sampled only when notLoadA low.
REQ-007 ALU_Result  input  WIDTH  load data.
REQ-008 clrErr  input  1  active-high synchronous clear of stackErr.
REQ-009 A_Result  output  WIDTH  accumulator value, registered.
REQ-010 A_Zero  output  1  combinational, high when A_Result == 0.
REQ-011 stackCount  output  $clog2(DEPTH+1)  number of valid stack entries, registered.
REQ-012 stackFull  output  1  high when stackCount == DEPTH.
REQ-013 stackEmpty  output  1  high when stackCount == 0.
REQ-014 stackErr  output  1  sticky error flag, registered.

Function
REQ-015 notLoadA high: A_Result, stack contents, stackCount unchanged; the op input is ignored.
REQ-016 notLoadA low, op 000 LOAD: A_Result <= ALU_Result on the next edge.
REQ-017 op 001 SHL: A_Result <= {A[WIDTH-2:0],0}; old MSB discarded.
REQ-018 op 010 SHR: A_Result <= {0,A[WIDTH-1:1]}.
REQ-019 op 011 INC: A_Result <= A+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-020 op 100 DEC: A_Result <= A-1 modulo 2^WIDTH; 0 wraps to all-ones.
REQ-021 op 101 CLR: A_Result <= 0.
REQ-022 op 110 PUSH, stack not full: A_Result written to entry[stackCount], stackCount +1, A_Result unchanged.
REQ-023 op 111 POP, stack not empty: A_Result <= entry[stackCount-1], stackCount -1.
REQ-024 PUSH when full: no write; stackCount and A_Result unchanged; stackErr <= 1.
REQ-025 POP when empty: A_Result and stackCount unchanged; stackErr <= 1.
REQ-026 Every operation completes in one cycle; the result is visible after the same rising edge.
REQ-027 Back-to-back PUSH/POP on consecutive cycles: each op acts on the state left by the previous edge; PUSH then POP returns the pushed value.
REQ-028 clrErr high, no new error in the same cycle: stackErr <= 0.
REQ-029 clrErr high while an error condition (REQ-024/025) occurs in the same cycle: stackErr <= 1; the set takes priority.
REQ-030 clrErr is honoured regardless of notLoadA.
REQ-031 Stack entries above stackCount are don't-care; they are not observable at any output.

Reset
REQ-032 reset high forces A_Result=0, stackCount=0, stackErr=0 immediately, without waiting for a clock edge.
REQ-033 reset asserted mid-operation aborts the op; no partial update persists after reset is released.
REQ-034 Stack entry storage does not need to be reset; after reset, POP reports empty (REQ-025).
REQ-035 First edge after reset deassertion acts normally on sampled inputs.

Verification (WIDTH=5, DEPTH=4)
REQ-036 Reset assert mid-cycle with A=10110 and count=2 -> A_Result=0, stackCount=0, stackErr=0, A_Zero=1 before the next edge.
REQ-037 LOAD 00011, INC, INC, DEC, SHL, SHR -> A sequence 00011, 00100, 00101, 00100, 01000, 00100; LOAD 11111 then INC -> 00000 with A_Zero=1; DEC -> 11111.
REQ-038 LOAD and PUSH values 1,2,3,4 -> stackFull=1; a 5th PUSH -> stackErr=1, count=4; four POPs -> A=4,3,2,1, stackEmpty=1.
REQ-039 POP on empty with A=00111 -> A unchanged, stackErr=1; clrErr alone -> 0; POP on empty with clrErr high in the same cycle -> stackErr stays 1.
REQ-040 notLoadA high with op=101 and ALU_Result=01010 for 3 cycles -> A_Result, stackCount unchanged.
REQ-041 PUSH 01001 then POP on the next cycle after a LOAD of 00000 -> A_Result=01001, stackCount back to its prior value.
